// File: rtl/xentry_pkg.sv
// Shared memory-side types plus the L2 arbiter state and requester indices.
package xentry_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        STORE = 2'd1
    } memory_operation_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic ARB_REQ_IC = 1'b0;
    localparam logic ARB_REQ_DC = 1'b1;

endpackage

// File: rtl/l2_arb_rr_picker.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side
// that was not served last.
module l2_arb_rr_picker (
    input  logic ic_valid,
    input  logic dc_valid,
    input  logic rr_last,
    output logic winner,
    output logic any_valid
);

    assign any_valid = ic_valid | dc_valid;
    assign winner    = (ic_valid & dc_valid) ? ~rr_last : dc_valid;

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 request port between icache (0) and dcache (1).
// Optional L2_ARB_LINE_LOCK_EN holds a grant for a whole cache line.
//
// state    | meaning
// ARB_IDLE | no grant; L2 port quiet, round-robin pick on any valid
// ARB_BUSY | owner's request forwarded to L2 until fulfilled/abandoned
module l2_arbiter
    import xentry_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int LINE_SIZE = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   ic_req_address,
    input  memory_operation_e ic_req_type,
    input  logic              ic_req_valid,
    input  logic [XLEN-1:0]   ic_word_to_store,
    output logic [XLEN-1:0]   ic_fetched_word,
    output logic              ic_req_fulfilled,
    input  logic [XLEN-1:0]   dc_req_address,
    input  memory_operation_e dc_req_type,
    input  logic              dc_req_valid,
    input  logic [XLEN-1:0]   dc_word_to_store,
    output logic [XLEN-1:0]   dc_fetched_word,
    output logic              dc_req_fulfilled,
    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    output logic [XLEN-1:0]   l2_word_to_store,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_req_fulfilled
);

    arb_state_e state;
    logic       owner;
    logic       rr_last;
    logic       pick_winner;
    logic       pick_any;
    logic       busy;
    logic       owner_valid;
    logic       fulfill_ok;

`ifdef L2_ARB_LINE_LOCK_EN
    localparam int WORDS_PER_LINE = LINE_SIZE / (XLEN / 8);
    localparam int LOCK_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(WORDS_PER_LINE - 1);
    logic [LOCK_W-1:0] lock_cnt;
`endif

    l2_arb_rr_picker u_picker (
        .ic_valid  (ic_req_valid),
        .dc_valid  (dc_req_valid),
        .rr_last   (rr_last),
        .winner    (pick_winner),
        .any_valid (pick_any)
    );

    assign busy        = (state == ARB_BUSY);
    assign owner_valid = (owner == ARB_REQ_DC) ? dc_req_valid : ic_req_valid;
    // A fulfilled landing in the reset cycle belongs to a transaction being torn down.
    assign fulfill_ok  = busy & ~reset & l2_req_fulfilled;

    assign ic_req_fulfilled = fulfill_ok & (owner == ARB_REQ_IC);
    assign dc_req_fulfilled = fulfill_ok & (owner == ARB_REQ_DC);
    assign ic_fetched_word  = l2_fetched_word;
    assign dc_fetched_word  = l2_fetched_word;

    always_comb begin
        l2_req_valid     = 1'b0;
        l2_req_address   = '0;
        l2_word_to_store = '0;
        l2_req_type      = memory_operation_e'(0);
        if (busy) begin
            l2_req_valid = owner_valid;
            if (owner == ARB_REQ_DC) begin
                l2_req_address   = dc_req_address;
                l2_word_to_store = dc_word_to_store;
                l2_req_type      = dc_req_type;
            end else begin
                l2_req_address   = ic_req_address;
                l2_word_to_store = ic_word_to_store;
                l2_req_type      = ic_req_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB_IDLE;
            owner   <= ARB_REQ_IC;
            rr_last <= ARB_REQ_DC;
`ifdef L2_ARB_LINE_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        owner <= pick_winner;
                        state <= ARB_BUSY;
`ifdef L2_ARB_LINE_LOCK_EN
                        lock_cnt <= LOCK_LOAD;
`endif
                    end
                end
                ARB_BUSY: begin
                    if (l2_req_fulfilled) begin
`ifdef L2_ARB_LINE_LOCK_EN
                        if (lock_cnt == '0) begin
                            rr_last <= owner;
                            state   <= ARB_IDLE;
                        end else begin
                            lock_cnt <= lock_cnt - LOCK_W'(1);
                        end
`else
                        rr_last <= owner;
                        state   <= ARB_IDLE;
`endif
                    end else if (!owner_valid) begin
                        // Abandoned request: release without advancing round-robin.
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter; the line-lock scenario follows L2_ARB_LINE_LOCK_EN.
module tb_l2_arbiter;
    import xentry_pkg::*;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [XLEN-1:0]   ic_req_address, dc_req_address;
    memory_operation_e ic_req_type, dc_req_type, l2_req_type;
    logic              ic_req_valid, dc_req_valid;
    logic [XLEN-1:0]   ic_word_to_store, dc_word_to_store;
    logic [XLEN-1:0]   ic_fetched_word, dc_fetched_word;
    logic              ic_req_fulfilled, dc_req_fulfilled;
    logic [XLEN-1:0]   l2_req_address, l2_word_to_store, l2_fetched_word;
    logic              l2_req_valid, l2_req_fulfilled;

    int vectors = 0;
    int miscompares = 0;

    l2_arbiter #(.XLEN(XLEN), .LINE_SIZE(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .ic_req_address   (ic_req_address),
        .ic_req_type      (ic_req_type),
        .ic_req_valid     (ic_req_valid),
        .ic_word_to_store (ic_word_to_store),
        .ic_fetched_word  (ic_fetched_word),
        .ic_req_fulfilled (ic_req_fulfilled),
        .dc_req_address   (dc_req_address),
        .dc_req_type      (dc_req_type),
        .dc_req_valid     (dc_req_valid),
        .dc_word_to_store (dc_word_to_store),
        .dc_fetched_word  (dc_fetched_word),
        .dc_req_fulfilled (dc_req_fulfilled),
        .l2_req_address   (l2_req_address),
        .l2_req_type      (l2_req_type),
        .l2_req_valid     (l2_req_valid),
        .l2_word_to_store (l2_word_to_store),
        .l2_fetched_word  (l2_fetched_word),
        .l2_req_fulfilled (l2_req_fulfilled)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ic_req_valid = 1'b0; ic_req_address = '0; ic_req_type = LOAD; ic_word_to_store = '0;
        dc_req_valid = 1'b0; dc_req_address = '0; dc_req_type = LOAD; dc_word_to_store = '0;
        l2_req_fulfilled = 1'b0; l2_fetched_word = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Wait (bounded) for the L2 request, expect one idle cycle first, then fulfil it.
    task automatic serve_txn(input string tag, input logic exp_dc, input logic [31:0] exp_addr,
                             input logic [31:0] data);
        int n = 0;
        while (!l2_req_valid && n < 8) begin
            tick();
            n++;
        end
        check_vec({tag, "_idle_gap"}, n, 1);
        check_vec({tag, "_addr"}, l2_req_address, exp_addr);
        l2_req_fulfilled = 1'b1;
        l2_fetched_word  = data;
        #1;
        check_vec({tag, "_ic_ful"}, {31'd0, ic_req_fulfilled}, {31'd0, ~exp_dc});
        check_vec({tag, "_dc_ful"}, {31'd0, dc_req_fulfilled}, {31'd0, exp_dc});
        tick();
        l2_req_fulfilled = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset_dut();
        check_vec("rst_valid", {31'd0, l2_req_valid}, 0);
        check_vec("rst_addr", l2_req_address, 0);
        check_vec("rst_data", l2_word_to_store, 0);
        check_vec("rst_type", {30'd0, l2_req_type}, 0);
        check_vec("rst_ic_ful", {31'd0, ic_req_fulfilled}, 0);
        check_vec("rst_dc_ful", {31'd0, dc_req_fulfilled}, 0);

        // Single dcache load
        dc_req_valid = 1'b1; dc_req_address = 32'h0000_1040; dc_req_type = LOAD;
        #1;
        check_vec("t1_idle_valid", {31'd0, l2_req_valid}, 0);
        tick();
        check_vec("t1_valid", {31'd0, l2_req_valid}, 1);
        check_vec("t1_addr", l2_req_address, 32'h0000_1040);
        check_vec("t1_type", {30'd0, l2_req_type}, {30'd0, LOAD});
        tick(); tick(); tick();
        l2_req_fulfilled = 1'b1; l2_fetched_word = 32'hDEAD_BEEF;
        #1;
        check_vec("t1_dc_ful", {31'd0, dc_req_fulfilled}, 1);
        check_vec("t1_dc_word", dc_fetched_word, 32'hDEAD_BEEF);
        check_vec("t1_ic_ful", {31'd0, ic_req_fulfilled}, 0);
        tick();
        l2_req_fulfilled = 1'b0; dc_req_valid = 1'b0;
        #1;
        check_vec("t1_dc_ful_end", {31'd0, dc_req_fulfilled}, 0);
        check_vec("t1_valid_end", {31'd0, l2_req_valid}, 0);

`ifndef L2_ARB_LINE_LOCK_EN
        // Tie out of reset: icache first, then dcache after one idle cycle
        reset_dut();
        ic_req_valid = 1'b1; ic_req_address = 32'h100;
        dc_req_valid = 1'b1; dc_req_address = 32'h200;
        tick();
        check_vec("t2_first_addr", l2_req_address, 32'h100);
        l2_req_fulfilled = 1'b1;
        #1;
        check_vec("t2_ic_ful", {31'd0, ic_req_fulfilled}, 1);
        check_vec("t2_dc_ful", {31'd0, dc_req_fulfilled}, 0);
        tick();
        l2_req_fulfilled = 1'b0; ic_req_valid = 1'b0;
        #1;
        check_vec("t2_idle", {31'd0, l2_req_valid}, 0);
        tick();
        check_vec("t2_second_valid", {31'd0, l2_req_valid}, 1);
        check_vec("t2_second_addr", l2_req_address, 32'h200);

        // Both continuously valid: strict alternation ic, dc, ic, ...
        reset_dut();
        ic_req_valid = 1'b1; ic_req_address = 32'h100;
        dc_req_valid = 1'b1; dc_req_address = 32'h200;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) serve_txn("t3_ic", 1'b0, 32'h100, 32'h1000 + i);
            else            serve_txn("t3_dc", 1'b1, 32'h200, 32'h1000 + i);
        end
`endif

        // dcache store: data and type stable through the busy period
        reset_dut();
        dc_req_valid = 1'b1; dc_req_address = 32'h300; dc_req_type = STORE;
        dc_word_to_store = 32'h1234_5678;
        tick();
        for (int c = 0; c < 3; c++) begin
            check_vec("t4_type", {30'd0, l2_req_type}, {30'd0, STORE});
            check_vec("t4_data", l2_word_to_store, 32'h1234_5678);
            tick();
        end
        l2_req_fulfilled = 1'b1;
        #1;
        check_vec("t4_dc_ful", {31'd0, dc_req_fulfilled}, 1);
        tick();
        clear_inputs();
        #1;

        // Reset mid icache transaction with fulfilled in the reset cycle
        reset_dut();
        ic_req_valid = 1'b1; ic_req_address = 32'h400;
        tick();
        check_vec("t5_valid", {31'd0, l2_req_valid}, 1);
        tick();
        reset = 1'b1; l2_req_fulfilled = 1'b1;
        #1;
        check_vec("t5_ic_ful_drop", {31'd0, ic_req_fulfilled}, 0);
        tick();
        reset = 1'b0; l2_req_fulfilled = 1'b0;
        dc_req_valid = 1'b1; dc_req_address = 32'h500;
        #1;
        check_vec("t5_post_rst_valid", {31'd0, l2_req_valid}, 0);
        tick();
        check_vec("t5_ic_preferred", l2_req_address, 32'h400);
        clear_inputs();
        #1;

        // Stray fulfilled in idle, then an abandoned icache request
        reset_dut();
        l2_req_fulfilled = 1'b1;
        #1;
        check_vec("t6_idle_ic_ful", {31'd0, ic_req_fulfilled}, 0);
        check_vec("t6_idle_dc_ful", {31'd0, dc_req_fulfilled}, 0);
        l2_req_fulfilled = 1'b0;
        ic_req_valid = 1'b1; ic_req_address = 32'h600;
        tick();
        check_vec("t6_valid", {31'd0, l2_req_valid}, 1);
        ic_req_valid = 1'b0;
        #1;
        check_vec("t6_drop_same_cycle", {31'd0, l2_req_valid}, 0);
        tick();
        ic_req_valid = 1'b1; dc_req_valid = 1'b1; dc_req_address = 32'h700;
        #1;
        check_vec("t6_back_idle", {31'd0, l2_req_valid}, 0);
        tick();
        check_vec("t6_rr_unchanged", l2_req_address, 32'h600);
        clear_inputs();
        #1;

        // dcache line fill while icache waits
        reset_dut();
        dc_req_valid = 1'b1; dc_req_address = 32'h700;
        tick();
        ic_req_valid = 1'b1; ic_req_address = 32'h800;
`ifdef L2_ARB_LINE_LOCK_EN
        for (int w = 0; w < 8; w++) begin
            #1;
            check_vec("t7_lock_addr", l2_req_address, 32'h700);
            l2_req_fulfilled = 1'b1;
            #1;
            check_vec("t7_lock_dc_ful", {31'd0, dc_req_fulfilled}, 1);
            check_vec("t7_lock_ic_ful", {31'd0, ic_req_fulfilled}, 0);
            tick();
            l2_req_fulfilled = 1'b0;
        end
        #1;
        check_vec("t7_release_idle", {31'd0, l2_req_valid}, 0);
        tick();
        check_vec("t7_ic_after_line", l2_req_address, 32'h800);
`else
        #1;
        check_vec("t7_addr", l2_req_address, 32'h700);
        l2_req_fulfilled = 1'b1;
        #1;
        check_vec("t7_dc_ful", {31'd0, dc_req_fulfilled}, 1);
        tick();
        l2_req_fulfilled = 1'b0;
        #1;
        check_vec("t7_release_idle", {31'd0, l2_req_valid}, 0);
        tick();
        check_vec("t7_ic_next", l2_req_address, 32'h800);
`endif
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single L2 request port between the icache (requester 0) and the dcache (requester 1).
- Uses the same valid/fulfilled protocol as the cache-side L2 interface: hold the request until a one-cycle fulfilled pulse.
- Round-robin grant, locked for the whole transaction. Sits between both L1 controllers and L2.

Parameters:
- XLEN, 32, address/data width in bits
- LINE_SIZE, 32, bytes per cache line; sets WORDS_PER_LINE = LINE_SIZE/(XLEN/8) for the line-lock option

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ic_req_address  in  XLEN  icache L2 request address
- ic_req_type  in  memory_operation_e  icache operation
- ic_req_valid  in  1  icache request valid
- ic_word_to_store  in  XLEN  icache store data
- ic_fetched_word  out  XLEN  read data to icache
- ic_req_fulfilled  out  1  completion pulse to icache
- dc_req_address  in  XLEN  dcache request address
- dc_req_type  in  memory_operation_e  dcache operation
- dc_req_valid  in  1  dcache request valid
- dc_word_to_store  in  XLEN  dcache store data
- dc_fetched_word  out  XLEN  read data to dcache
- dc_req_fulfilled  out  1  completion pulse to dcache
- l2_req_address  out  XLEN  to L2
- l2_req_type  out  memory_operation_e  to L2
- l2_req_valid  out  1  to L2
- l2_word_to_store  out  XLEN  to L2
- l2_fetched_word  in  XLEN  from L2
- l2_req_fulfilled  in  1  one-cycle completion from L2

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Registered state: FSM {ARB_IDLE, ARB_BUSY}, owner (1 bit), rr_last (1 bit).
- Reset values: state ARB_IDLE, owner 0, rr_last 1 (icache wins the first tie).
- Outputs in ARB_IDLE: l2_req_valid 0, l2_req_address 0, l2_word_to_store 0, l2_req_type = enum encoding 0. Both *_req_fulfilled are 0.
- ARB_IDLE: if any *_req_valid, set owner = winner and go to ARB_BUSY.
  - Winner is the sole requester, or, if both request, the one not equal to rr_last.
- ARB_BUSY: l2_req_* are driven from the owner's inputs combinationally; l2_req_valid = owner's req_valid.
- Arbitration latency: the request reaches L2 exactly 1 cycle after valid is first seen in ARB_IDLE.
- On l2_req_fulfilled in ARB_BUSY:
  - pulse the owner's *_req_fulfilled in the same cycle (combinational pass-through);
  - set rr_last = owner and return to ARB_IDLE.
- The non-owner's fulfilled output is always 0.
- ic_fetched_word and dc_fetched_word both carry l2_fetched_word unconditionally; they are meaningful only when the matching fulfilled pulses.
- Requesters hold address, type and data stable until fulfilled. A non-owner keeps waiting; no starvation, because rr alternates whenever both are pending.
- Owner drops valid in ARB_BUSY without fulfilled (protocol violation): l2_req_valid falls in the same cycle, and the FSM goes to ARB_IDLE next cycle with rr_last unchanged.
- l2_req_fulfilled while in ARB_IDLE is ignored; no pulse reaches either requester.
- Reset asserted mid-transaction: next cycle is ARB_IDLE with l2_req_valid 0. An in-flight fulfilled in that cycle is dropped.
- Back-to-back: re-arbitration takes 1 IDLE cycle after every fulfilled.

Optional Feature:
- Macro: L2_ARB_LINE_LOCK_EN.
- Defined: a grant persists across up to WORDS_PER_LINE consecutive fulfilled handshakes, so a line fill or writeback is not interleaved.
  - A lock counter loads WORDS_PER_LINE-1 on grant and decrements per fulfilled.
  - Return to ARB_IDLE when the counter reaches 0 on a fulfilled, or when the owner's valid is low for one full cycle in ARB_BUSY.
- Undefined: grant is released after every single fulfilled, as described above; no counter exists.

Decomposition:
- xentry_pkg gains arb_state_e {ARB_IDLE, ARB_BUSY} and localparams ARB_REQ_IC = 0, ARB_REQ_DC = 1.
- One natural sub-module: l2_arb_rr_picker, a combinational 2-way round-robin pick from (ic_valid, dc_valid, rr_last) returning winner and any_valid.
- Muxing and the FSM stay in l2_arbiter.

Test Plan:
- Single dc request, addr 0x0000_1040, LOAD: l2_req_valid rises 1 cycle later with address 0x0000_1040. L2 fulfills with 0xDEADBEEF after 3 cycles: dc_req_fulfilled pulses for one cycle with dc_fetched_word 0xDEADBEEF, and ic_req_fulfilled stays 0.
- Both valid out of reset (ic 0x100, dc 0x200): icache granted first. After its fulfilled, one IDLE cycle, then dc 0x200 appears on L2.
- Both continuously valid for 6 transactions: grants alternate ic, dc, ic, dc, ic, dc, and no requester is starved.
- dc STORE, addr 0x300, data 0x12345678: l2_word_to_store = 0x12345678 and l2_req_type = STORE for the whole ARB_BUSY period.
- Reset asserted 2 cycles into an ic transaction, with fulfilled arriving in the reset cycle: l2_req_valid is 0 the next cycle, no fulfilled reaches ic, and the following arbitration prefers ic.
- With L2_ARB_LINE_LOCK_EN (LINE_SIZE 32): dc issues 8 back-to-back word requests while ic is also valid. ic receives no grant until the 8th dc fulfilled.
